simon_ctrl: RTL

//   Control FSM and sequencing counters for the Simon datapath.
//   - Each pclk edge is one user press; the block advances through INPUT -> PLAYBACK -> REPEAT (-> INPUT | DONE).
//   - Drives the pattern memory write enable and address, the LED source select and the mode LEDs.
//   - Checks each guess against the memory read data and enforces the difficulty level.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_pattern_check.sv | 25 ++
 rtl/simon_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon controller.
//   - state_t       : controller state encoding (INPUT, PLAYBACK, REPEAT, DONE)
//   - LED_MODE_*    : mode LED patterns shown for each state
//   - LED_SEL_*     : pattern LED source select (switches or memory)
//   - SIMON_*       : default DEPTH / AW / PW for the controller
package simon_pkg;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
    localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
    localparam logic [2:0] LED_MODE_DONE     = 3'b111;

    localparam logic LED_SEL_SW  = 1'b0;
    localparam logic LED_SEL_MEM = 1'b1;

    localparam int SIMON_DEPTH = 64;
    localparam int SIMON_AW    = 6;
    localparam int SIMON_PW    = 4;

endpackage

// File: rtl/simon_pattern_check.sv
// Combinational guess/legality checker for the Simon controller.
// Ports:
//   pattern    in  PW  switch value (new entry or guess)
//   mem_rdata  in  PW  stored entry at the current address
//   eff_level  in  1   1 = hard (any pattern), 0 = easy (one-hot only)
//   legal      out 1   pattern may be stored at the current difficulty
//   match      out 1   pattern equals the stored entry
module simon_pattern_check #(
    parameter int PW = 4
) (
    input  logic [PW-1:0] pattern,
    input  logic [PW-1:0] mem_rdata,
    input  logic          eff_level,
    output logic          legal,
    output logic          match
);

    logic w_onehot;

    // $onehot is false for all-zero, so an empty pattern is illegal in easy mode.
    assign w_onehot = $onehot(pattern);
    assign legal    = eff_level | w_onehot;
    assign match    = (pattern == mem_rdata);

endmodule

// File: rtl/simon_ctrl.sv
// Control FSM and sequencing counters for the Simon game datapath.
// Every rising pclk edge is one user press. Flow:
//   INPUT -> PLAYBACK -> REPEAT -> (INPUT | DONE)
// Ports:
//   pclk       in  1   press clock
//   rst        in  1   asynchronous active-low reset
//   level      in  1   difficulty for the first entry (1 = hard, 0 = easy)
//   pattern    in  PW  new entry in INPUT, guess in REPEAT
//   mem_rdata  in  PW  pattern memory read data (async read of mem_addr)
//   mem_we     out 1   pattern memory write strobe
//   mem_addr   out AW  write address in INPUT, read address otherwise
//   led_sel    out 1   0 = LEDs show switches, 1 = LEDs show memory
//   mode_leds  out 3   current state indication
//   won        out 1   set in DONE after a full DEPTH-long correct repeat
module simon_ctrl
    import simon_pkg::*;
#(
    parameter int DEPTH = simon_pkg::SIMON_DEPTH,
    parameter int AW    = simon_pkg::SIMON_AW,
    parameter int PW    = simon_pkg::SIMON_PW
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          level,
    input  logic [PW-1:0] pattern,
    input  logic [PW-1:0] mem_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          led_sel,
    output logic [2:0]    mode_leds,
    output logic          won
);

    localparam int          CNT_W    = AW + 1;
    localparam logic [AW:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    state_t        r_st;
    logic [AW:0]   r_cnt;
    logic [AW-1:0] r_idx;
    logic          r_level;
    logic          r_won;

    state_t        w_st_next;
    logic [AW:0]   w_cnt_next;
    logic [AW-1:0] w_idx_next;
    logic          w_level_next;
    logic          w_won_next;

    logic w_cnt_zero;
    logic w_eff_level;
    logic w_legal;
    logic w_match;
    logic w_idx_last;
    logic w_full;

    // The difficulty is only sampled while the game is empty; afterwards
    // the latched copy governs, so flipping the switch mid-game is ignored.
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_eff_level = w_cnt_zero ? level : r_level;
    assign w_idx_last  = ({1'b0, r_idx} == (r_cnt - CNT_ONE));
    assign w_full      = (r_cnt == CNT_FULL);

    simon_pattern_check #(
        .PW (PW)
    ) u_check (
        .pattern   (pattern),
        .mem_rdata (mem_rdata),
        .eff_level (w_eff_level),
        .legal     (w_legal),
        .match     (w_match)
    );

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_st    <= ST_INPUT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_level <= 1'b0;
            r_won   <= 1'b0;
        end else begin
            r_st    <= w_st_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_level <= w_level_next;
            r_won   <= w_won_next;
        end
    end

    always_comb begin
        w_st_next    = r_st;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_level_next = r_level;
        w_won_next   = r_won;
        mem_we       = 1'b0;
        mem_addr     = r_idx;
        led_sel      = LED_SEL_SW;
        mode_leds    = LED_MODE_INPUT;

        case (r_st)
            ST_INPUT: begin
                mode_leds = LED_MODE_INPUT;
                mem_addr  = r_cnt[AW-1:0];
                // Gated by rst so a reset held across an edge never writes.
                mem_we    = w_legal & rst;
                if (w_legal) begin
                    w_cnt_next = r_cnt + CNT_ONE;
                    w_idx_next = '0;
                    w_st_next  = ST_PLAYBACK;
                    if (w_cnt_zero) begin
                        w_level_next = level;
                    end
                end
            end
            ST_PLAYBACK: begin
                mode_leds = LED_MODE_PLAYBACK;
                led_sel   = LED_SEL_MEM;
                if (w_idx_last) begin
                    w_idx_next = '0;
                    w_st_next  = ST_REPEAT;
                end else begin
                    w_idx_next = r_idx + IDX_ONE;
                end
            end
            ST_REPEAT: begin
                mode_leds = LED_MODE_REPEAT;
                if (!w_match) begin
                    w_idx_next = '0;
                    w_won_next = 1'b0;
                    w_st_next  = ST_DONE;
                end else if (w_idx_last) begin
                    w_idx_next = '0;
                    if (w_full) begin
                        w_won_next = 1'b1;
                        w_st_next  = ST_DONE;
                    end else begin
                        w_st_next  = ST_INPUT;
                    end
                end else begin
                    w_idx_next = r_idx + IDX_ONE;
                end
            end
            ST_DONE: begin
                mode_leds  = LED_MODE_DONE;
                led_sel    = LED_SEL_MEM;
                w_idx_next = w_idx_last ? '0 : (r_idx + IDX_ONE);
            end
            default: begin
                w_st_next = ST_INPUT;
            end
        endcase
    end

    assign won = r_won;

endmodule
